// File: rtl/eval_reporter.sv
// Branch/IPC evaluation reporter: queues evaluation records in a small FIFO
// and streams each one as a 3-byte {tag, value_hi, value_lo} message.
module eval_reporter #(
    parameter int         BR_CNT_W   = 10,
    parameter int         IPC_CNT_W  = 10,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] TAG_BR     = 8'hB5,
    parameter logic [7:0] TAG_IPC    = 8'hC1
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_br_eval_upd,
    input  logic [BR_CNT_W-1:0]             i_br_eval,
    input  logic                            i_ipc_eval_upd,
    input  logic [IPC_CNT_W-1:0]            i_ipc_eval,
    output logic [7:0]                      o_tx_data,
    output logic                            o_tx_vld,
    input  logic                            i_tx_rdy,
    output logic [7:0]                      o_drop_cnt,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_fifo_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic        is_ipc;
        logic [15:0] val;
    } rec_t;

    typedef enum logic [1:0] {IDLE, TAG, HI, LO} state_t;

    rec_t          mem [FIFO_DEPTH];
    rec_t          head, hold, br_rec, ipc_rec;
    logic [AW-1:0] wr_ptr, rd_ptr, ipc_idx;
    logic [CW-1:0] count;
    logic [CW:0]   free;
    logic          wr_br, wr_ipc, pop;
    logic [1:0]    n_drop;
    logic [8:0]    drop_sum;
    state_t        state, state_nx;
    logic [7:0]    data_nx;
    logic          vld_nx;

    assign head       = mem[rd_ptr];
    assign br_rec     = '{is_ipc: 1'b0, val: 16'(i_br_eval)};
    assign ipc_rec    = '{is_ipc: 1'b1, val: 16'(i_ipc_eval)};
    assign o_fifo_cnt = count;

    always_comb begin
        pop      = 1'b0;
        state_nx = state;
        data_nx  = o_tx_data;
        vld_nx   = o_tx_vld;
        case (state)
            IDLE: begin
                vld_nx = 1'b0;
                if (count != '0) begin
                    pop      = 1'b1;
                    state_nx = TAG;
                    data_nx  = head.is_ipc ? TAG_IPC : TAG_BR;
                    vld_nx   = 1'b1;
                end
            end
            TAG: if (i_tx_rdy) begin
                state_nx = HI;
                data_nx  = hold.val[15:8];
            end
            HI: if (i_tx_rdy) begin
                state_nx = LO;
                data_nx  = hold.val[7:0];
            end
            LO: if (i_tx_rdy) begin
                if (count != '0) begin
                    pop      = 1'b1;
                    state_nx = TAG;
                    data_nx  = head.is_ipc ? TAG_IPC : TAG_BR;
                end else begin
                    state_nx = IDLE;
                    vld_nx   = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A same-cycle pop frees its slot for incoming writes; branch has priority.
    always_comb begin
        free     = (CW+1)'(FIFO_DEPTH) - {1'b0, count} + (CW+1)'(pop);
        wr_br    = i_br_eval_upd && (free >= (CW+1)'(1));
        wr_ipc   = i_ipc_eval_upd && (free >= (i_br_eval_upd ? (CW+1)'(2) : (CW+1)'(1)));
        ipc_idx  = wr_ptr + AW'(wr_br);
        n_drop   = 2'(i_br_eval_upd && !wr_br) + 2'(i_ipc_eval_upd && !wr_ipc);
        drop_sum = {1'b0, o_drop_cnt} + 9'(n_drop);
    end

    always_ff @(posedge i_clk) begin
        if (wr_br)  mem[wr_ptr]  <= br_rec;
        if (wr_ipc) mem[ipc_idx] <= ipc_rec;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            o_tx_data  <= 8'h00;
            o_tx_vld   <= 1'b0;
            hold       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_drop_cnt <= '0;
        end else begin
            state     <= state_nx;
            o_tx_data <= data_nx;
            o_tx_vld  <= vld_nx;
            if (pop) begin
                hold   <= head;
                rd_ptr <= rd_ptr + AW'(1);
            end
            wr_ptr     <= wr_ptr + AW'(wr_br) + AW'(wr_ipc);
            count      <= count + CW'(wr_br) + CW'(wr_ipc) - CW'(pop);
            o_drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

endmodule

// File: tb/tb_eval_reporter.sv
// Directed bench for eval_reporter: framing, back-to-back records,
// backpressure, overflow/saturation and asynchronous reset.
module tb_eval_reporter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       br_upd = 1'b0, ipc_upd = 1'b0, rdy = 1'b0;
    logic [9:0] br_val = '0, ipc_val = '0;
    logic [7:0] tx_data, drop_cnt;
    logic       tx_vld;
    logic [2:0] fifo_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    eval_reporter #(
        .BR_CNT_W  (10),
        .IPC_CNT_W (10),
        .FIFO_DEPTH(4),
        .TAG_BR    (8'hB5),
        .TAG_IPC   (8'hC1)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_br_eval_upd (br_upd),
        .i_br_eval     (br_val),
        .i_ipc_eval_upd(ipc_upd),
        .i_ipc_eval    (ipc_val),
        .o_tx_data     (tx_data),
        .o_tx_vld      (tx_vld),
        .i_tx_rdy      (rdy),
        .o_drop_cnt    (drop_cnt),
        .o_fifo_cnt    (fifo_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic byte_chk(input string tag, input logic [7:0] exp);
        chk({tag, "_vld"}, 32'(tx_vld), 32'd1);
        chk({tag, "_data"}, 32'(tx_data), 32'(exp));
    endtask

    initial begin
        // reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_vld", 32'(tx_vld), 0);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_cnt", 32'(fifo_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single branch record 937 = 0x3A9
        rdy = 1'b1; br_upd = 1'b1; br_val = 10'd937;
        @(negedge clk); br_upd = 1'b0;
        chk("t1_lat_vld", 32'(tx_vld), 0);
        chk("t1_cnt1", 32'(fifo_cnt), 1);
        @(negedge clk); byte_chk("t1_tag", 8'hB5);
        chk("t1_cnt0", 32'(fifo_cnt), 0);
        @(negedge clk); byte_chk("t1_hi", 8'h03);
        @(negedge clk); byte_chk("t1_lo", 8'hA9);
        @(negedge clk); chk("t1_idle", 32'(tx_vld), 0);

        // simultaneous strobes, branch first, no bubble
        br_upd = 1'b1; br_val = 10'h155; ipc_upd = 1'b1; ipc_val = 10'h2A0;
        @(negedge clk); br_upd = 1'b0; ipc_upd = 1'b0;
        chk("t2_cnt2", 32'(fifo_cnt), 2);
        chk("t2_lat_vld", 32'(tx_vld), 0);
        @(negedge clk); byte_chk("t2_b0", 8'hB5);
        chk("t2_cnt1", 32'(fifo_cnt), 1);
        @(negedge clk); byte_chk("t2_b1", 8'h01);
        @(negedge clk); byte_chk("t2_b2", 8'h55);
        @(negedge clk); byte_chk("t2_b3", 8'hC1);
        @(negedge clk); byte_chk("t2_b4", 8'h02);
        @(negedge clk); byte_chk("t2_b5", 8'hA0);
        @(negedge clk); chk("t2_idle", 32'(tx_vld), 0);

        // backpressure during the HI byte
        br_upd = 1'b1; br_val = 10'h2CD;
        @(negedge clk); br_upd = 1'b0;
        @(negedge clk); byte_chk("t3_tag", 8'hB5);
        @(negedge clk); byte_chk("t3_hi", 8'h02);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); byte_chk("t3_hold", 8'h02);
        end
        rdy = 1'b1;
        @(negedge clk); byte_chk("t3_lo", 8'hCD);
        @(negedge clk); chk("t3_idle", 32'(tx_vld), 0);

        // overflow: six IPC strobes, sink stalled
        rdy = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            ipc_upd = 1'b1; ipc_val = 10'(k);
            @(negedge clk);
        end
        ipc_upd = 1'b0;
        chk("t4_cnt", 32'(fifo_cnt), 4);
        chk("t4_drop1", 32'(drop_cnt), 1);
        byte_chk("t4_tag", 8'hC1);
        ipc_upd = 1'b1; ipc_val = 10'h3FF;
        for (int i = 0; i < 300; i++) @(negedge clk);
        ipc_upd = 1'b0;
        chk("t4_drop_sat", 32'(drop_cnt), 255);
        chk("t4_cnt_full", 32'(fifo_cnt), 4);
        rdy = 1'b1;
        for (int r = 1; r <= 5; r++) begin
            byte_chk("t4_drain_tag", 8'hC1);
            @(negedge clk); byte_chk("t4_drain_hi", 8'h00);
            @(negedge clk); byte_chk("t4_drain_lo", 8'(r));
            @(negedge clk);
        end
        chk("t4_idle", 32'(tx_vld), 0);
        chk("t4_drop_hold", 32'(drop_cnt), 255);

        // reset in the middle of the LO byte
        br_upd = 1'b1; br_val = 10'h0F0;
        @(negedge clk); br_upd = 1'b0;
        @(negedge clk); byte_chk("t5_tag", 8'hB5);
        @(negedge clk); byte_chk("t5_hi", 8'h00);
        @(negedge clk); byte_chk("t5_lo", 8'hF0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_vld", 32'(tx_vld), 0);
        chk("t5_rst_data", 32'(tx_data), 0);
        chk("t5_rst_drop", 32'(drop_cnt), 0);
        chk("t5_rst_cnt", 32'(fifo_cnt), 0);
        br_upd = 1'b1; br_val = 10'h111;
        @(negedge clk);
        chk("t5_ign_cnt", 32'(fifo_cnt), 0);
        br_val = 10'h3FF;
        rst_n = 1'b1;
        @(negedge clk); br_upd = 1'b0;
        chk("t5_cnt1", 32'(fifo_cnt), 1);
        chk("t5_lat_vld", 32'(tx_vld), 0);
        @(negedge clk); byte_chk("t5_new_tag", 8'hB5);
        @(negedge clk); byte_chk("t5_new_hi", 8'h03);
        @(negedge clk); byte_chk("t5_new_lo", 8'hFF);
        @(negedge clk); chk("t5_idle", 32'(tx_vld), 0);
        chk("t5_cnt0", 32'(fifo_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
